// File: rtl/booth_pkg.sv
// booth_pkg: shared types and constants for the radix-16 Booth
// partial-product generator.
//   MUL_W   - operand width (signed multiplicand / multiplier)
//   PROD_W  - product and partial-product width
//   NUM_PP  - number of radix-16 digits, one partial product each
//   DIGIT_W - multiplier bits consumed per digit
//   booth_digit_t - recoded digit as sign + magnitude (0..8)
//   pp_array_t    - packed bundle of all partial products
package booth_pkg;
  localparam int MUL_W   = 32;
  localparam int PROD_W  = 64;
  localparam int NUM_PP  = 8;
  localparam int DIGIT_W = 4;

  // Widths of the precomputed hard multiples, signed.
  localparam int X3_W = MUL_W + 2;
  localparam int X5_W = MUL_W + 3;
  localparam int X7_W = MUL_W + 3;

  typedef struct packed {
    logic       neg;
    logic [3:0] mag;
  } booth_digit_t;

  typedef logic [NUM_PP-1:0][PROD_W-1:0] pp_array_t;
endpackage

// File: rtl/booth_pp_gen_if.sv
// booth_pp_gen_if: operand and partial-product handshake bundle.
//   in_valid/in_ready/in_x/in_y/in_tag : operand channel (master -> slave)
//   out_valid/out_ready/pp0..pp7/out_tag : result channel (slave -> master)
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. A producer holding valid keeps its payload stable until the
// transfer; the block's in_ready never looks at in_valid, and its outputs
// stay stable while out_valid && !out_ready.
interface booth_pp_gen_if #(
  parameter int TAG_W = 4
) ();
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_x;
  logic [31:0]      in_y;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      pp0, pp1, pp2, pp3, pp4, pp5, pp6, pp7;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_x, in_y, in_tag, out_ready,
    input  in_ready, out_valid, pp0, pp1, pp2, pp3, pp4, pp5, pp6, pp7, out_tag
  );

  modport slave (
    input  in_valid, in_x, in_y, in_tag, out_ready,
    output in_ready, out_valid, pp0, pp1, pp2, pp3, pp4, pp5, pp6, pp7, out_tag
  );
endinterface

// File: rtl/booth_r16_enc.sv
// booth_r16_enc: combinational radix-16 Booth recoder.
//   win   - 5-bit window {y[4i+3], y[4i+2], y[4i+1], y[4i], y[4i-1]}
//   digit - signed digit in -8..+8 as {neg, mag}
module booth_r16_enc
  import booth_pkg::*;
(
  input  logic [DIGIT_W:0] win,
  output booth_digit_t     digit
);
  logic [4:0] val;
  logic [4:0] abs_val;

  always_comb begin
    // Top four bits read as a signed nibble, plus the borrowed lower bit.
    val       = {win[DIGIT_W], win[DIGIT_W:1]} + {4'b0000, win[0]};
    abs_val   = val[4] ? (~val + 5'd1) : val;
    digit.neg = val[4];
    digit.mag = abs_val[3:0];
  end
endmodule

// File: rtl/booth_pp_gen.sv
// booth_pp_gen: two-stage radix-16 Booth partial-product generator.
//   clk, rst      - single clock, asynchronous active-high reset
//   bus (slave)   - operand channel in, eight shifted 64-bit partial
//                   products plus tag out; their sum mod 2^64 is x*y
//   perf_ops      - accepted-operation count  (BOOTH_PP_GEN_PERF_EN only)
//   perf_stall    - cycles with in_valid && !in_ready (BOOTH_PP_GEN_PERF_EN only)
// Stage 1 registers the operands and the hard multiples 3x/5x/7x; stage 2
// recodes y, selects +/-{0..8}x per digit and registers the products.
module booth_pp_gen
  import booth_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  booth_pp_gen_if.slave        bus
`ifdef BOOTH_PP_GEN_PERF_EN
  ,
  output logic [31:0]          perf_ops,
  output logic [31:0]          perf_stall
`endif
);
  logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic s2_free, in_ready, accept, advance;

  logic [MUL_W-1:0] x_q, x_d, y_q, y_d;
  logic [TAG_W-1:0] tag_q, tag_d, out_tag_q, out_tag_d;
  logic [X3_W-1:0]  x3_q, x3_d;
  logic [X5_W-1:0]  x5_q, x5_d;
  logic [X7_W-1:0]  x7_q, x7_d;
  pp_array_t        pp_q, pp_d;

  logic [X3_W-1:0]  x_ext3;
  logic [X5_W-1:0]  x_ext5;
  logic [PROD_W-1:0] xs;
  logic [PROD_W-1:0] mult [NUM_PP];
  logic [MUL_W:0]   y_win;
  booth_digit_t     digit [NUM_PP];

  assign s2_free  = !s2_valid_q || bus.out_ready;
  assign in_ready = !s1_valid_q || s2_free;
  assign accept   = bus.in_valid && in_ready;
  assign advance  = s1_valid_q && s2_free;

  // y[-1] is the implicit zero below the LSB.
  assign y_win = {y_q, 1'b0};

  for (genvar g = 0; g < NUM_PP; g++) begin : g_enc
    booth_r16_enc u_enc (
      .win   (y_win[DIGIT_W*g + DIGIT_W -: DIGIT_W+1]),
      .digit (digit[g])
    );
  end

  always_comb begin
    // Stage 1: operands and hard multiples.
    x_ext3 = {{(X3_W-MUL_W){bus.in_x[MUL_W-1]}}, bus.in_x};
    x_ext5 = {{(X5_W-MUL_W){bus.in_x[MUL_W-1]}}, bus.in_x};
    s1_valid_d = accept ? 1'b1 : (advance ? 1'b0 : s1_valid_q);
    x_d   = accept ? bus.in_x   : x_q;
    y_d   = accept ? bus.in_y   : y_q;
    tag_d = accept ? bus.in_tag : tag_q;
    x3_d  = accept ? (x_ext3 + {x_ext3[X3_W-2:0], 1'b0})     : x3_q;
    x5_d  = accept ? (x_ext5 + {x_ext5[X5_W-3:0], 2'b00})    : x5_q;
    x7_d  = accept ? ({x_ext5[X7_W-4:0], 3'b000} - x_ext5)   : x7_q;

    // Stage 2: digit-driven multiple selection, negation and shift.
    xs = {{(PROD_W-MUL_W){x_q[MUL_W-1]}}, x_q};
    s2_valid_d = advance ? 1'b1 : (bus.out_ready ? 1'b0 : s2_valid_q);
    out_tag_d  = advance ? tag_q : out_tag_q;
    pp_d       = pp_q;
    for (int i = 0; i < NUM_PP; i++) begin
      case (digit[i].mag)
        4'd1:    mult[i] = xs;
        4'd2:    mult[i] = xs << 1;
        4'd3:    mult[i] = {{(PROD_W-X3_W){x3_q[X3_W-1]}}, x3_q};
        4'd4:    mult[i] = xs << 2;
        4'd5:    mult[i] = {{(PROD_W-X5_W){x5_q[X5_W-1]}}, x5_q};
        4'd6:    mult[i] = {{(PROD_W-X3_W){x3_q[X3_W-1]}}, x3_q} << 1;
        4'd7:    mult[i] = {{(PROD_W-X7_W){x7_q[X7_W-1]}}, x7_q};
        4'd8:    mult[i] = xs << 3;
        default: mult[i] = '0;
      endcase
      if (digit[i].neg) mult[i] = -mult[i];
      if (advance) pp_d[i] = mult[i] << (DIGIT_W*i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      tag_q      <= '0;
      x3_q       <= '0;
      x5_q       <= '0;
      x7_q       <= '0;
      pp_q       <= '0;
      out_tag_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      x_q        <= x_d;
      y_q        <= y_d;
      tag_q      <= tag_d;
      x3_q       <= x3_d;
      x5_q       <= x5_d;
      x7_q       <= x7_d;
      pp_q       <= pp_d;
      out_tag_q  <= out_tag_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.pp0 = pp_q[0];
  assign bus.pp1 = pp_q[1];
  assign bus.pp2 = pp_q[2];
  assign bus.pp3 = pp_q[3];
  assign bus.pp4 = pp_q[4];
  assign bus.pp5 = pp_q[5];
  assign bus.pp6 = pp_q[6];
  assign bus.pp7 = pp_q[7];

`ifdef BOOTH_PP_GEN_PERF_EN
  logic [31:0] perf_ops_q, perf_ops_d, perf_stall_q, perf_stall_d;

  always_comb begin
    perf_ops_d   = perf_ops_q + {31'd0, accept};
    perf_stall_d = perf_stall_q + {31'd0, bus.in_valid && !in_ready};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_ops_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_ops_q   <= perf_ops_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_ops   = perf_ops_q;
  assign perf_stall = perf_stall_q;
`endif
endmodule

// File: tb/tb_booth_pp_gen.sv
// tb_booth_pp_gen: bench for booth_pp_gen. Directed test-plan cases, a
// stall/capacity sequence, mid-flight reset and a randomized stream, all
// scored against an integer-arithmetic Booth model and x*y.
// Build with BOOTH_PP_GEN_PERF_EN defined to also score the counters.
module tb_booth_pp_gen;
  import booth_pkg::*;

  localparam int TAG_W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  booth_pp_gen_if #(.TAG_W(TAG_W)) bus ();

`ifdef BOOTH_PP_GEN_PERF_EN
  logic [31:0] perf_ops, perf_stall;
  logic [31:0] exp_ops, exp_stall;
`endif

  booth_pp_gen #(.TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef BOOTH_PP_GEN_PERF_EN
    ,
    .perf_ops   (perf_ops),
    .perf_stall (perf_stall)
`endif
  );

  logic [63:0] obs_pp [NUM_PP];
  always_comb begin
    obs_pp[0] = bus.pp0; obs_pp[1] = bus.pp1; obs_pp[2] = bus.pp2; obs_pp[3] = bus.pp3;
    obs_pp[4] = bus.pp4; obs_pp[5] = bus.pp5; obs_pp[6] = bus.pp6; obs_pp[7] = bus.pp7;
  end

  // ---------------- scoreboard ----------------
  // Each entry: {tag, x, y} of an accepted operation, in acceptance order.
  logic [TAG_W+63:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int acc_cnt;
  bit last_acc;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Reference: digit value straight from the recoding formula, times x.
  function automatic logic [63:0] model_pp(input logic [31:0] x, input logic [31:0] y, input int i);
    logic [32:0] ye;
    int b4, b3, b2, b1, b0, d;
    longint p;
    ye = {y, 1'b0};
    b4 = int'(ye[4*i+4]); b3 = int'(ye[4*i+3]); b2 = int'(ye[4*i+2]);
    b1 = int'(ye[4*i+1]); b0 = int'(ye[4*i]);
    d = -8*b4 + 4*b3 + 2*b2 + b1 + b0;
    p = longint'(d) * longint'($signed(x));
    return 64'(p) << (4*i);
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'h7fff_ffff;
      2: return 32'hffff_ffff;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- driver ----------------
  // One clock: score outputs and capacity at the negedge, update the
  // scoreboard, then return #1 after the rising edge.
  task automatic cycle();
    int n;
    logic [TAG_W+63:0] head;
    logic [63:0] sum, prod;
    logic acc;
    @(negedge clk);
    n = exp_q.size();
    chk("in_ready", 64'(bus.in_ready), 64'((n < 2) || bus.out_ready));
    if (bus.out_valid) begin
      if (n == 0) begin
        chk("out_valid_without_pending", 64'(bus.out_valid), 64'(0));
      end else begin
        head = exp_q[0];
        sum = '0;
        for (int i = 0; i < NUM_PP; i++) begin
          chk($sformatf("pp%0d", i), obs_pp[i], model_pp(head[63:32], head[31:0], i));
          sum += obs_pp[i];
        end
        prod = 64'(longint'($signed(head[63:32])) * longint'($signed(head[31:0])));
        chk("pp_sum", sum, prod);
        chk("out_tag", 64'(bus.out_tag), 64'(head[TAG_W+63:64]));
      end
    end
    acc = bus.in_valid && bus.in_ready;
    last_acc = acc;
    if (acc) acc_cnt++;
`ifdef BOOTH_PP_GEN_PERF_EN
    if (acc) exp_ops++;
    if (bus.in_valid && !bus.in_ready) exp_stall++;
`endif
    if (bus.out_valid && bus.out_ready && n > 0) void'(exp_q.pop_front());
    if (acc) exp_q.push_back({bus.in_tag, bus.in_x, bus.in_y});
    @(posedge clk);
    #1;
`ifdef BOOTH_PP_GEN_PERF_EN
    chk("perf_ops", 64'(perf_ops), 64'(exp_ops));
    chk("perf_stall", 64'(perf_stall), 64'(exp_stall));
`endif
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) cycle();
    chk("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic run_directed(input string name, input logic [31:0] x, input logic [31:0] y,
                              input logic [TAG_W-1:0] tag, input pp_array_t exp_pp);
    bus.in_x = x; bus.in_y = y; bus.in_tag = tag;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    cycle();
    chk({name, "_accepted"}, 64'(last_acc), 64'(1));
    bus.in_valid = 1'b0;
    chk({name, "_lat1"}, 64'(bus.out_valid), 64'(0));
    cycle();
    chk({name, "_lat2"}, 64'(bus.out_valid), 64'(1));
    for (int i = 0; i < NUM_PP; i++)
      chk($sformatf("%s_pp%0d", name, i), obs_pp[i], exp_pp[i]);
    chk({name, "_tag"}, 64'(bus.out_tag), 64'(tag));
    cycle();
  endtask

  task automatic check_reset_state(input string name);
    chk({name, "_out_valid"}, 64'(bus.out_valid), 64'(0));
    chk({name, "_in_ready"}, 64'(bus.in_ready), 64'(1));
    for (int i = 0; i < NUM_PP; i++)
      chk($sformatf("%s_pp%0d", name, i), obs_pp[i], 64'(0));
    chk({name, "_out_tag"}, 64'(bus.out_tag), 64'(0));
`ifdef BOOTH_PP_GEN_PERF_EN
    chk({name, "_perf_ops"}, 64'(perf_ops), 64'(0));
    chk({name, "_perf_stall"}, 64'(perf_stall), 64'(0));
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    pp_array_t e;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_x = '0; bus.in_y = '0; bus.in_tag = '0;
    bus.out_ready = 1'b1;
`ifdef BOOTH_PP_GEN_PERF_EN
    exp_ops = '0; exp_stall = '0;
`endif
    #12;
    check_reset_state("reset");
    #10 rst = 1'b0;
    @(posedge clk); #1;

    // Directed test-plan cases.
    e = '0; e[0] = 64'd15;
    run_directed("x3y5", 32'd3, 32'd5, 4'h5, e);
    e = '0; e[0] = 64'hFFFF_FFFF_FFFF_FFC8; e[1] = 64'h70;
    run_directed("x7y8", 32'd7, 32'd8, 4'hA, e);
    e = '0; e[7] = 64'h0000_0000_8000_0000;
    run_directed("xm1ymin", 32'hFFFF_FFFF, 32'h8000_0000, 4'h3, e);
    e = '0; e[7] = 64'h4000_0000_0000_0000;
    run_directed("xminymin", 32'h8000_0000, 32'h8000_0000, 4'hC, e);
    drain();

    // Stall: out_ready low for 4 cycles accepts exactly two operations.
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; acc_cnt = 0;
    repeat (4) begin
      bus.in_x = rand_word(); bus.in_y = rand_word(); bus.in_tag = TAG_W'($urandom);
      cycle();
    end
    chk("stall_accepts", 64'(acc_cnt), 64'(2));
    chk("stall_in_ready", 64'(bus.in_ready), 64'(0));
    bus.out_ready = 1'b1; acc_cnt = 0;
    repeat (6) begin
      bus.in_x = rand_word(); bus.in_y = rand_word(); bus.in_tag = TAG_W'($urandom);
      cycle();
    end
    chk("resume_accepts", 64'(acc_cnt), 64'(6));
    drain();

    // Reset with two operations in flight.
    bus.out_ready = 1'b0; bus.in_valid = 1'b1;
    repeat (2) begin
      bus.in_x = rand_word(); bus.in_y = rand_word(); bus.in_tag = TAG_W'($urandom);
      cycle();
    end
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
`ifdef BOOTH_PP_GEN_PERF_EN
    exp_ops = '0; exp_stall = '0;
`endif
    check_reset_state("midrst");
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    repeat (5) cycle();

    // Randomized stream with random in_valid / out_ready.
    for (int k = 0; k < 400; k++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.in_x = rand_word(); bus.in_y = rand_word(); bus.in_tag = TAG_W'($urandom);
      cycle();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
